// File: rtl/rr_arb_pkg.sv
// Shared types and limits for the round-robin one-hot arbiter.
package rr_arb_pkg;

   localparam int unsigned N_MIN = 1;
   localparam int unsigned N_MAX = 64;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority search: first set req bit at or after ptr.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic [IW-1:0] win_idx
);

   logic found;

   // Upper segment [ptr..N-1] first, then wrap to the lowest set bit overall.
   always_comb begin
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (!found && req[i] && (i >= int'(ptr))) begin
            win[i]  = 1'b1;
            win_idx = IW'(i);
            found   = 1'b1;
         end
      end
      for (int i = 0; i < int'(N); i++) begin
         if (!found && req[i]) begin
            win[i]  = 1'b1;
            win_idx = IW'(i);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: grant held until done, one idle bubble between grants,
// sticky err if the registered grant is ever multi-hot.
module rr_onehot_arbiter
   import rr_arb_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [N-1:0]                      req,
   input  logic                              done,
   output logic [N-1:0]                      gnt,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx,
   output logic                              busy,
   output logic                              err
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   if ((N < N_MIN) || (N > N_MAX)) begin : g_bad_n
      $error("rr_onehot_arbiter: N out of range");
   end

   arb_state_e    state;
   arb_state_e    state_nxt;
   logic [IW-1:0] ptr;
   logic [IW-1:0] ptr_nxt;
   logic [N-1:0]  gnt_nxt;
   logic [IW-1:0] idx_nxt;
   logic [N-1:0]  pick_win;
   logic [IW-1:0] pick_idx;
   logic          multi_hot;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req     (req),
      .ptr     (ptr),
      .win     (pick_win),
      .win_idx (pick_idx)
   );

   assign multi_hot = |(gnt & (gnt - N'(1)));

   // Next-state and next-output decode.
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      idx_nxt   = gnt_idx;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = GRANT;
               gnt_nxt   = pick_win;
               idx_nxt   = pick_idx;
            end else begin
               gnt_nxt = '0;
               idx_nxt = '0;
            end
         end
         GRANT: begin
            if (done) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               idx_nxt   = '0;
               ptr_nxt   = (gnt_idx == IW'(N - 1)) ? '0 : (gnt_idx + IW'(1));
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         gnt     <= '0;
         gnt_idx <= '0;
         busy    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         gnt     <= gnt_nxt;
         gnt_idx <= idx_nxt;
         busy    <= (state_nxt == GRANT);
         err     <= err | multi_hot;
      end
   end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter (N = 4) against a behavioural model.
module tb_rr_onehot_arbiter;

   localparam int N = 4;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic         done;
   logic [N-1:0] gnt;
   logic [1:0]   gnt_idx;
   logic         busy;
   logic         err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int           m_ptr;
   int           m_idx;
   logic [N-1:0] m_gnt;
   bit           m_busy;
   bit           m_err;

   rr_onehot_arbiter #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .busy    (busy),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_idx  = 0;
      m_gnt  = '0;
      m_busy = 0;
      m_err  = 0;
   endtask

   // One rising edge of the arbiter, described by the rules rather than by state bits.
   task automatic model_edge(input logic [N-1:0] r, input logic d);
      int k;
      if (m_busy) begin
         if (d) begin
            m_ptr  = (m_idx + 1) % N;
            m_busy = 0;
            m_gnt  = '0;
            m_idx  = 0;
         end
      end else if (r != '0) begin
         for (int i = N - 1; i >= 0; i--) begin
            k = (m_ptr + i) % N;
            if (r[k]) m_idx = k;
         end
         m_gnt  = '0;
         m_gnt[m_idx] = 1'b1;
         m_busy = 1;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".gnt"},  64'(gnt),     64'(m_gnt));
      check({tag, ".idx"},  64'(gnt_idx), 64'(m_idx));
      check({tag, ".busy"}, 64'(busy),    64'(m_busy));
      check({tag, ".err"},  64'(err),     64'(m_err));
   endtask

   // Inputs are set at a negedge before calling; checks land on the following negedge.
   task automatic cycle(input string tag);
      logic [N-1:0] r;
      logic         d;
      r = req;
      d = done;
      @(posedge clk);
      model_edge(r, d);
      @(negedge clk);
      check_all(tag);
   endtask

   // Async reset pulse entirely between edges; called at a negedge.
   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      req  = '0;
      done = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all("reset");
      rst = 1'b0;

      // Basic grant and rotation after release
      req = 4'b1010;
      cycle("basic");
      check("basic_gnt", 64'(gnt), 64'h2);
      check("basic_idx", 64'(gnt_idx), 64'd1);
      done = 1'b1;
      cycle("release");
      check("bubble_gnt", 64'(gnt), 64'h0);
      done = 1'b0;
      cycle("rotate");
      check("rotate_gnt", 64'(gnt), 64'h8);
      check("rotate_idx", 64'(gnt_idx), 64'd3);

      // Fairness and wrap with all requesters active
      @(negedge clk);
      pulse_reset("rst_fair");
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         logic [N-1:0] ord;
         ord = 4'b0001 << (k % 4);
         done = 1'b0;
         cycle("fair_grant");
         check("fair_order", 64'(gnt), 64'(ord));
         done = 1'b1;
         cycle("fair_release");
         check("fair_bubble", 64'(busy), 64'd0);
      end
      done = 1'b0;

      // Stable hold while the holder drops req, then done in IDLE is ignored
      req = 4'b0001;
      cycle("hold_grant");
      req = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         cycle("hold");
         check("hold_gnt", 64'(gnt), 64'h1);
      end
      done = 1'b1;
      cycle("hold_release");
      cycle("idle_done");
      check("idle_done_busy", 64'(busy), 64'd0);
      done = 1'b0;

      // Reset mid-grant abandons the grant and restarts from ptr 0
      pulse_reset("rst_a");
      req = 4'b0100;
      cycle("pre_mid");
      check("pre_mid_gnt", 64'(gnt), 64'h4);
      pulse_reset("rst_mid");
      check("mid_rst_gnt", 64'(gnt), 64'h0);
      req = 4'b0110;
      cycle("post_rst");
      check("post_rst_gnt", 64'(gnt), 64'h2);

      // Randomized traffic with occasional async resets
      for (int k = 0; k < 400; k++) begin
         req  = N'($urandom);
         done = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 79) == 0) pulse_reset("rnd_rst");
         cycle("rnd");
      end

      // Forced two-hot grant sets err, which stays until reset
      req  = '0;
      done = 1'b0;
      pulse_reset("rst_chk");
      force dut.gnt = 4'b0011;
      @(posedge clk);
      @(negedge clk);
      check("err_set", 64'(err), 64'd1);
      release dut.gnt;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("err_sticky", 64'(err), 64'd1);
      end
      pulse_reset("rst_clear");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/rr_onehot_arbiter.md
RR_ONEHOT_ARBITER -- requirements
Module: rr_onehot_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, giving the number of requesters (legal range 1..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port req, input, N bits: per-requester request, level-sensitive.
REQ-005 SHALL have port done, input, 1 bit: the current grant holder releases the resource.
REQ-006 SHALL have port gnt, output, N bits: registered one-hot-or-zero grant.
REQ-007 SHALL have port gnt_idx, output, max(1,$clog2(N)) bits: binary index of the asserted gnt bit, 0 when gnt is 0.
REQ-008 SHALL have port busy, output, 1 bit: a grant is outstanding.
REQ-009 SHALL have port err, output, 1 bit: sticky flag set when gnt violates one-hot-or-zero.

Function
REQ-010 SHALL implement two states: IDLE (no grant) and GRANT (one grant held).
REQ-011 In IDLE with req != 0, the block SHALL select the first set req bit at or after pointer ptr, searching circularly upward.
REQ-012 On that edge the block SHALL enter GRANT and register the winner into gnt. Latency is 1 cycle from req sampled to gnt visible.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-014 In GRANT, gnt SHALL be held stable regardless of req, including when the holder deasserts req. There is no revocation.
REQ-015 In GRANT with done = 1, the next edge SHALL clear gnt, return to IDLE, and set ptr to (winner index + 1) mod N.
REQ-016 Exactly one idle bubble cycle SHALL separate consecutive grants.
REQ-017 ptr SHALL wrap from N-1 to 0.
REQ-018 done SHALL be ignored in IDLE.
REQ-019 busy SHALL equal (state == GRANT).
REQ-020 gnt_idx SHALL be registered together with gnt and always remain consistent with it.
REQ-021 err SHALL set on any edge where the registered gnt has popcount > 1, and SHALL clear only on reset.
REQ-022 For N = 1: the requester is granted whenever req = 1 in IDLE, ptr stays 0, and gnt_idx = 0.

Reset
REQ-023 On rst assertion, gnt, gnt_idx, busy, err, ptr and state SHALL go to 0/IDLE immediately, without waiting for a clock edge.
REQ-024 Reset asserted mid-grant SHALL abandon the grant. The first post-reset arbitration SHALL start from ptr = 0.
REQ-025 The first arbitration SHALL occur on the first rising clk edge after rst deasserts.

Structure
REQ-026 Package rr_arb_pkg SHALL hold the state enum typedef (IDLE, GRANT) and the N range limits.
REQ-027 The circular priority search SHALL be one combinational sub-module, rr_pick, with inputs req and ptr and outputs a one-hot winner and its index.
REQ-028 The rest of the logic (FSM, ptr register, output registers, err checker) SHALL live in rr_onehot_arbiter.

Verification (N = 4)
REQ-029 Basic grant: reset, then req = 4'b1010 -> next edge gnt = 4'b0010, gnt_idx = 1, busy = 1.
REQ-030 Rotation after release: from REQ-029, done = 1 for one cycle -> gnt = 0 for one cycle, then gnt = 4'b1000, gnt_idx = 3.
REQ-031 Fairness and wrap: req = 4'b1111 held, done pulsed once per grant -> grant order 0001, 0010, 0100, 1000, 0001, with one bubble between each.
REQ-032 Stable hold: granted requester drops req while done = 0 for 5 cycles -> gnt unchanged throughout. A done pulse in IDLE causes no state change.
REQ-033 Reset mid-grant: rst pulse while gnt = 4'b0100 -> gnt, busy, ptr = 0 immediately. After release, req = 4'b0110 -> gnt = 4'b0010.
REQ-034 Checker: err SHALL stay 0 across all of the scenarios above. A forced two-hot gnt SHALL set err, and err SHALL remain set until rst.
